// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths, control-bit layout and bubble constant
package core_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;

  // Control vector layout: {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, alu_op[1:0]}
  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_ALU_OP     = 0;  // lsb of the 2-bit alu_op field

  // A bubble carries no side effects: no write, no memory access, no branch.
  localparam logic [CTRL_W-1:0] CTRL_NOP = 8'h00;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector (EX load vs ID sources)
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              valid_ex,
  input  logic              mem_read_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              valid_id,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  output logic              hz
);

  // A load writing x0 produces nothing to wait for, so rd_ex == 0 never stalls.
  always_comb begin
    hz = valid_ex & mem_read_ex & (rd_ex != '0) & valid_id &
         ((rd_ex == rs1_id) | (rd_ex == rs2_id));
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID->EX pipeline register with load-use bubble insertion (optional ID_EX_PERF_CNT_EN counters)
module id_ex_stage_reg
  import core_pkg::*;
#(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int REG_AW = core_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              valid_id,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic [DATA_W-1:0] rs1_data_id,
  input  logic [DATA_W-1:0] rs2_data_id,
  input  logic [DATA_W-1:0] imm_id,
  input  logic [DATA_W-1:0] pc_id,
  input  logic [7:0]        ctrl_id,
  input  logic              stall,
  input  logic              flush,
  output logic              valid_ex,
  output logic [REG_AW-1:0] rs1_ex,
  output logic [REG_AW-1:0] rs2_ex,
  output logic [REG_AW-1:0] rd_ex,
  output logic [DATA_W-1:0] rs1_data_ex,
  output logic [DATA_W-1:0] rs2_data_ex,
  output logic [DATA_W-1:0] imm_ex,
  output logic [DATA_W-1:0] pc_ex,
  output logic [7:0]        ctrl_ex,
  output logic              load_use_hold
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       hold_cnt
`endif
);

  logic hz;

  load_use_detect #(
    .REG_AW(REG_AW)
  ) u_load_use_detect (
    .valid_ex    (valid_ex),
    .mem_read_ex (ctrl_ex[CTRL_MEM_READ]),
    .rd_ex       (rd_ex),
    .valid_id    (valid_id),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .hz          (hz)
  );

  // A flush discards the ID instruction anyway, so upstream need not hold it.
  always_comb begin
    load_use_hold = hz & ~flush;
  end

  // Stage register: flush beats stall beats hazard; invalid ID words become bubbles
  // so indices of a dead slot can never match in the forwarding logic.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_ex    <= 1'b0;
      rs1_ex      <= '0;
      rs2_ex      <= '0;
      rd_ex       <= '0;
      rs1_data_ex <= '0;
      rs2_data_ex <= '0;
      imm_ex      <= '0;
      pc_ex       <= '0;
      ctrl_ex     <= CTRL_NOP;
    end else if (flush || (!stall && (hz || !valid_id))) begin
      valid_ex    <= 1'b0;
      rs1_ex      <= '0;
      rs2_ex      <= '0;
      rd_ex       <= '0;
      rs1_data_ex <= '0;
      rs2_data_ex <= '0;
      imm_ex      <= '0;
      pc_ex       <= '0;
      ctrl_ex     <= CTRL_NOP;
    end else if (!stall) begin
      valid_ex    <= 1'b1;
      rs1_ex      <= rs1_id;
      rs2_ex      <= rs2_id;
      rd_ex       <= rd_id;
      rs1_data_ex <= rs1_data_id;
      rs2_data_ex <= rs2_data_id;
      imm_ex      <= imm_id;
      pc_ex       <= pc_id;
      ctrl_ex     <= ctrl_id;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  // Counts only hazard bubbles that actually enter EX (not flush bubbles) and every stalled cycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bubble_cnt <= '0;
      hold_cnt   <= '0;
    end else begin
      if (!flush && !stall && hz) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
      if (stall) begin
        hold_cnt <= hold_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [7:0]  ctrl;
  } out_t;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        valid_id = 1'b0;
  logic [4:0]  rs1_id = '0, rs2_id = '0, rd_id = '0;
  logic [31:0] rs1_data_id = '0, rs2_data_id = '0, imm_id = '0, pc_id = '0;
  logic [7:0]  ctrl_id = '0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        valid_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic [31:0] rs1_data_ex, rs2_data_ex, imm_ex, pc_ex;
  logic [7:0]  ctrl_ex;
  logic        load_use_hold;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bubble_cnt, hold_cnt;
  int          exp_bub = 0, exp_hold = 0;
`endif

  int   total = 0;
  int   bad = 0;
  out_t ms;
  out_t sb[$];
  out_t exp_o;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk(clk), .arst_n(arst_n), .valid_id(valid_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id),
    .imm_id(imm_id), .pc_id(pc_id), .ctrl_id(ctrl_id),
    .stall(stall), .flush(flush),
    .valid_ex(valid_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex),
    .imm_ex(imm_ex), .pc_ex(pc_ex), .ctrl_ex(ctrl_ex),
    .load_use_hold(load_use_hold)
`ifdef ID_EX_PERF_CNT_EN
    , .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
`endif
  );

  function automatic out_t obs();
    return {valid_ex, rs1_ex, rs2_ex, rd_ex, rs1_data_ex, rs2_data_ex, imm_ex, pc_ex, ctrl_ex};
  endfunction

  function automatic logic model_hz(out_t s);
    return s.valid && s.ctrl[6] && (s.rd != 5'd0) && valid_id &&
           ((s.rd == rs1_id) || (s.rd == rs2_id));
  endfunction

  function automatic logic model_hold(out_t s);
    return model_hz(s) && !flush;
  endfunction

  function automatic out_t model_next(out_t s);
    out_t n;
    n = '0;
    if (flush) n = '0;
    else if (stall) n = s;
    else if (model_hz(s)) n = '0;
    else if (!valid_id) n = '0;
    else n = {1'b1, rs1_id, rs2_id, rd_id, rs1_data_id, rs2_data_id, imm_id, pc_id, ctrl_id};
    return n;
  endfunction

  // Predict from current inputs, queue the expectation, then clock.
  task automatic step();
    out_t n;
    #1;
    n = model_next(ms);
`ifdef ID_EX_PERF_CNT_EN
    if (!flush && !stall && model_hz(ms)) exp_bub++;
    if (stall) exp_hold++;
`endif
    sb.push_back(n);
    @(posedge clk);
    #1;
    ms = n;
  endtask

  task automatic set_id(logic v, logic [4:0] a, logic [4:0] b, logic [4:0] d, logic [7:0] c);
    valid_id = v; rs1_id = a; rs2_id = b; rd_id = d; ctrl_id = c;
    rs1_data_id = $urandom; rs2_data_id = $urandom; imm_id = $urandom; pc_id = $urandom;
  endtask

  task automatic test_reset();
    set_id(1'b1, 5'd7, 5'd8, 5'd9, 8'hD0);
    arst_n = 1'b1;
    step();
    exp_o = sb.pop_front();
    total++;
    if (obs() !== exp_o) begin bad++; $display("FAIL reset_pre_capture act=%h exp=%h", obs(), exp_o); end
    @(posedge clk); #3;
    arst_n = 1'b0;
    #1;
    total++;
    if (obs() !== '0) begin bad++; $display("FAIL reset_outputs act=%h exp=0", obs()); end
    total++;
    if (load_use_hold !== 1'b0) begin bad++; $display("FAIL reset_hold act=%b exp=0", load_use_hold); end
    ms = '0;
    sb.delete();
    @(negedge clk);
    arst_n = 1'b1;
`ifdef ID_EX_PERF_CNT_EN
    exp_bub = 0; exp_hold = 0;
`endif
  endtask

  task automatic test_pass_through();
    set_id(1'b1, 5'd3, 5'd4, 5'd5, 8'h81);
    rs1_data_id = 32'h11;
    step();
    exp_o = sb.pop_front();
    total++;
    if (obs() !== exp_o) begin bad++; $display("FAIL pass_through act=%h exp=%h", obs(), exp_o); end
    total++;
    if ({valid_ex, rs1_ex, rd_ex, rs1_data_ex, ctrl_ex} !== {1'b1, 5'd3, 5'd5, 32'h11, 8'h81}) begin
      bad++; $display("FAIL pass_through_fields act=%b/%0d/%0d/%h/%h exp=1/3/5/11/81",
                      valid_ex, rs1_ex, rd_ex, rs1_data_ex, ctrl_ex);
    end
  endtask

  task automatic test_load_use();
    set_id(1'b1, 5'd2, 5'd2, 5'd5, 8'hD0);   // lw x5
    step();
    exp_o = sb.pop_front();
    total++;
    if (obs() !== exp_o) begin bad++; $display("FAIL lu_load act=%h exp=%h", obs(), exp_o); end
    set_id(1'b1, 5'd1, 5'd5, 5'd6, 8'h80);   // add x6, x1, x5
    #1;
    total++;
    if (load_use_hold !== 1'b1) begin bad++; $display("FAIL lu_hold_high act=%b exp=1", load_use_hold); end
    step();
    exp_o = sb.pop_front();
    total++;
    if (obs() !== exp_o || valid_ex !== 1'b0 || rd_ex !== 5'd0) begin
      bad++; $display("FAIL lu_bubble act=%h exp=%h", obs(), exp_o);
    end
    total++;
    if (load_use_hold !== 1'b0) begin bad++; $display("FAIL lu_hold_drop act=%b exp=0", load_use_hold); end
    step();
    exp_o = sb.pop_front();
    total++;
    if (obs() !== exp_o || rd_ex !== 5'd6 || valid_ex !== 1'b1) begin
      bad++; $display("FAIL lu_add_capture act=%h exp=%h", obs(), exp_o);
    end
  endtask

  task automatic test_x0();
    set_id(1'b1, 5'd1, 5'd1, 5'd0, 8'hC0);   // load to x0
    step();
    exp_o = sb.pop_front();
    total++;
    if (obs() !== exp_o) begin bad++; $display("FAIL x0_load act=%h exp=%h", obs(), exp_o); end
    set_id(1'b1, 5'd0, 5'd0, 5'd4, 8'h80);
    #1;
    total++;
    if (load_use_hold !== 1'b0) begin bad++; $display("FAIL x0_hold act=%b exp=0", load_use_hold); end
    step();
    exp_o = sb.pop_front();
    total++;
    if (obs() !== exp_o || rd_ex !== 5'd4) begin bad++; $display("FAIL x0_capture act=%h exp=%h", obs(), exp_o); end
  endtask

  task automatic test_priority();
    out_t held;
    set_id(1'b1, 5'd9, 5'd10, 5'd11, 8'h88);
    step();
    held = sb.pop_front();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'(i + 12), 5'd13, 5'd14, 8'h8B);
      step();
      exp_o = sb.pop_front();
      total++;
      if (obs() !== exp_o || obs() !== held) begin bad++; $display("FAIL stall_hold%0d act=%h exp=%h", i, obs(), held); end
    end
    flush = 1'b1;
    step();
    exp_o = sb.pop_front();
    total++;
    if (obs() !== exp_o || valid_ex !== 1'b0) begin bad++; $display("FAIL flush_over_stall act=%h exp=%h", obs(), exp_o); end
    stall = 1'b0; flush = 1'b0;
    // hazard together with flush
    set_id(1'b1, 5'd3, 5'd3, 5'd7, 8'hD0);
    step();
    void'(sb.pop_front());
    set_id(1'b1, 5'd7, 5'd1, 5'd8, 8'h80);
    flush = 1'b1;
    #1;
    total++;
    if (load_use_hold !== 1'b0) begin bad++; $display("FAIL hz_flush_hold act=%b exp=0", load_use_hold); end
    step();
    exp_o = sb.pop_front();
    total++;
    if (obs() !== exp_o || valid_ex !== 1'b0) begin bad++; $display("FAIL hz_flush_bubble act=%h exp=%h", obs(), exp_o); end
    flush = 1'b0;
  endtask

  task automatic test_stall_during_hazard();
    set_id(1'b1, 5'd1, 5'd1, 5'd12, 8'hD0);
    step();
    void'(sb.pop_front());
    set_id(1'b1, 5'd12, 5'd2, 5'd13, 8'h80);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (load_use_hold !== 1'b1) begin bad++; $display("FAIL sh_hold%0d act=%b exp=1", i, load_use_hold); end
      step();
      exp_o = sb.pop_front();
      total++;
      if (obs() !== exp_o || rd_ex !== 5'd12) begin bad++; $display("FAIL sh_frozen%0d act=%h exp=%h", i, obs(), exp_o); end
    end
    stall = 1'b0;
    step();
    exp_o = sb.pop_front();
    total++;
    if (obs() !== exp_o || valid_ex !== 1'b0) begin bad++; $display("FAIL sh_bubble act=%h exp=%h", obs(), exp_o); end
    step();
    exp_o = sb.pop_front();
    total++;
    if (obs() !== exp_o || rd_ex !== 5'd13) begin bad++; $display("FAIL sh_capture act=%h exp=%h", obs(), exp_o); end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    for (int i = 0; i < 300; i++) begin
      set_id($urandom_range(3, 0) != 0, 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
             5'($urandom_range(3, 0)), 8'($urandom));
      stall = ($urandom_range(4, 0) == 0);
      flush = ($urandom_range(7, 0) == 0);
      #1;
      total++;
      if (load_use_hold !== model_hold(ms)) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_hold%0d act=%b exp=%b", i, load_use_hold, model_hold(ms));
      end
      step();
      exp_o = sb.pop_front();
      total++;
      if (obs() !== exp_o) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rand_out%0d act=%h exp=%h", i, obs(), exp_o);
      end
    end
    stall = 1'b0; flush = 1'b0;
  endtask

`ifdef ID_EX_PERF_CNT_EN
  task automatic test_perf_cnt();
    int b0, h0;
    b0 = exp_bub; h0 = exp_hold;
    total++;
    if (bubble_cnt !== 32'(exp_bub) || hold_cnt !== 32'(exp_hold)) begin
      bad++; $display("FAIL perf_running act=%0d/%0d exp=%0d/%0d", bubble_cnt, hold_cnt, exp_bub, exp_hold);
    end
    for (int k = 0; k < 2; k++) begin
      set_id(1'b1, 5'd1, 5'd1, 5'd20, 8'hD0);
      step();
      set_id(1'b1, 5'd20, 5'd1, 5'd21, 8'h80);
      step();
      step();
    end
    stall = 1'b1;
    for (int k = 0; k < 4; k++) step();
    stall = 1'b0;
    sb.delete();
    total++;
    if (bubble_cnt - 32'(b0) !== 32'd2 || hold_cnt - 32'(h0) !== 32'd4) begin
      bad++; $display("FAIL perf_delta act=%0d/%0d exp=2/4", bubble_cnt - 32'(b0), hold_cnt - 32'(h0));
    end
  endtask
`endif

  initial begin
    ms = '0;
    #12;
    test_reset();
    test_pass_through();
    test_load_use();
    test_x0();
    test_priority();
    test_stall_during_hazard();
    test_back_to_back();
`ifdef ID_EX_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
